// File: rtl/fpu_stream_gen.sv
// fpu_stream_gen
//   Stimulus streamer and latency monitor for FPU unit benches. A table of
//   DEPTH operand vectors is preloaded while idle. A run then issues
//   num_vec vectors over valid/ready, with gap idle cycles after each
//   transfer, and counts the FPU's output handshakes.
//
//   Optional feature macro: FPU_STREAM_GEN_LAT_EN
//     defined   : per-transaction latency tracking (timestamp FIFO, free
//                 running 16-bit cycle counter, max_lat_o)
//     undefined : max_lat_o tied to 0, no timestamp storage
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   wr_en_i/addr/data     table write port (honoured only in IDLE/DONE)
//   num_vec_i, gap_i      run length and inter-vector gap, latched at start
//   start_i               launch a run (honoured only in IDLE/DONE)
//   operands_o, valid_o   vector to the FPU, ready_i handshake
//   resp_i                FPU output handshake (out_valid & out_ready)
//   busy_o, done_o        run in progress / run complete (sticky)
//   sent_cnt_o/recv_cnt_o transfers / counted responses this run
//   max_lat_o             maximum issue-to-response latency
//   err_o                 sticky: response with nothing outstanding
module fpu_stream_gen #(
    parameter int WIDTH        = 32,
    parameter int NUM_OPERANDS = 3,
    parameter int DEPTH        = 16,
    parameter int GAP_W        = 4,
    parameter int AW           = $clog2(DEPTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic [AW-1:0]                 wr_addr_i,
    input  logic [NUM_OPERANDS*WIDTH-1:0] wr_data_i,
    input  logic [AW:0]                   num_vec_i,
    input  logic [GAP_W-1:0]              gap_i,
    input  logic                          start_i,
    output logic [NUM_OPERANDS*WIDTH-1:0] operands_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    input  logic                          resp_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [AW:0]                   sent_cnt_o,
    output logic [AW:0]                   recv_cnt_o,
    output logic [15:0]                   max_lat_o,
    output logic                          err_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_GAP   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                          r_state, w_next;
    logic [NUM_OPERANDS*WIDTH-1:0]   r_table [DEPTH];
    logic [AW-1:0]                   r_rd_ptr;
    logic [AW:0]                     r_num_vec, r_sent, r_recv;
    logic [GAP_W-1:0]                r_gap, r_gap_cnt;
    logic                            r_err;

    logic                            w_idle_like, w_start, w_xfer;
    logic                            w_last, w_resp_ok, w_resp_bad;
    logic [AW:0]                     w_outst;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_start     = start_i && w_idle_like;
    assign w_xfer      = valid_o && ready_i;
    assign w_outst     = r_sent - r_recv;
    assign w_last      = (r_sent + (AW+1)'(1)) == r_num_vec;
    // A response pairs only with transactions already outstanding before this
    // cycle; a same-cycle issue can never be its partner.
    assign w_resp_ok   = resp_i && (w_outst != '0);
    assign w_resp_bad  = resp_i && (w_outst == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) w_next = (num_vec_i == '0) ? S_DONE : S_SEND;
            end
            S_SEND: begin
                if (ready_i) begin
                    if (w_last)            w_next = S_DRAIN;
                    else if (r_gap != '0)  w_next = S_GAP;
                    else                   w_next = S_SEND;
                end
            end
            // gap counter is loaded with the (nonzero) gap on each transfer
            S_GAP:   if (r_gap_cnt <= GAP_W'(1)) w_next = S_SEND;
            S_DRAIN: if (w_outst == '0)          w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        valid_o    = (r_state == S_SEND);
        busy_o     = (r_state == S_SEND) || (r_state == S_GAP) || (r_state == S_DRAIN);
        done_o     = (r_state == S_DONE);
        operands_o = valid_o ? r_table[r_rd_ptr] : '0;
    end

    assign sent_cnt_o = r_sent;
    assign recv_cnt_o = r_recv;
    assign err_o      = r_err;

    // ---------------- run datapath ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr  <= '0;
            r_num_vec <= '0;
            r_sent    <= '0;
            r_recv    <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_err     <= 1'b0;
        end else if (w_start) begin
            r_rd_ptr  <= '0;
            r_num_vec <= num_vec_i;
            r_sent    <= '0;
            r_recv    <= '0;
            r_gap     <= gap_i;
            r_gap_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_sent    <= r_sent + (AW+1)'(1);
                r_gap_cnt <= r_gap;
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
            if (w_resp_ok)  r_recv <= r_recv + (AW+1)'(1);
            if (w_resp_bad) r_err  <= 1'b1;
        end
    end

    // Table contents survive reset so a restart can re-send them.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && w_idle_like) r_table[wr_addr_i] <= wr_data_i;
    end

`ifdef FPU_STREAM_GEN_LAT_EN
    // ---------------- latency monitor ----------------
    logic [15:0]   r_cycle, r_max_lat;
    logic [15:0]   r_stamp [DEPTH];
    logic [AW-1:0] r_ts_wp, r_ts_rp;
    logic [15:0]   w_lat;

    // modulo-2^16 difference handles counter wrap
    assign w_lat = r_cycle - r_stamp[r_ts_rp];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cycle   <= '0;
            r_ts_wp   <= '0;
            r_ts_rp   <= '0;
            r_max_lat <= '0;
        end else begin
            r_cycle <= r_cycle + 16'd1;
            if (w_start) begin
                r_ts_wp   <= '0;
                r_ts_rp   <= '0;
                r_max_lat <= '0;
            end else begin
                if (w_xfer) r_ts_wp <= r_ts_wp + AW'(1);
                if (w_resp_ok) begin
                    r_ts_rp <= r_ts_rp + AW'(1);
                    if (w_lat > r_max_lat) r_max_lat <= w_lat;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_xfer) r_stamp[r_ts_wp] <= r_cycle;
    end

    assign max_lat_o = r_max_lat;
`else
    assign max_lat_o = '0;
`endif

endmodule

// File: tb/tb_fpu_stream_gen.sv
module tb_fpu_stream_gen;
    localparam int WIDTH = 32, NOP = 3, DEPTH = 16, GAP_W = 4, AW = 4;
`ifdef FPU_STREAM_GEN_LAT_EN
    localparam logic [15:0] EXP_LAT = 16'd3;
`else
    localparam logic [15:0] EXP_LAT = 16'd0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr_en = 1'b0;
    logic [AW-1:0]        wr_addr = '0;
    logic [NOP*WIDTH-1:0] wr_data = '0;
    logic [AW:0]          num_vec = '0;
    logic [GAP_W-1:0]     gap = '0;
    logic                 start = 1'b0;
    logic [NOP*WIDTH-1:0] operands;
    logic                 valid;
    logic                 ready = 1'b0;
    logic                 resp = 1'b0;
    logic                 busy, done, err;
    logic [AW:0]          sent, recv;
    logic [15:0]          max_lat;

    int total = 0;
    int bad   = 0;

    fpu_stream_gen #(.WIDTH(WIDTH), .NUM_OPERANDS(NOP), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .num_vec_i(num_vec), .gap_i(gap), .start_i(start), .operands_o(operands),
        .valid_o(valid), .ready_i(ready), .resp_i(resp), .busy_o(busy), .done_o(done),
        .sent_cnt_o(sent), .recv_cnt_o(recv), .max_lat_o(max_lat), .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic logic [NOP*WIDTH-1:0] vec(input int i);
        logic [31:0] a, b, c;
        a = 32'h1000_0000 + 32'(i);
        b = 32'h2000_0000 + 32'(i);
        c = 32'h3000_0000 + 32'(i);
        return {c, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cyc, nx, nr, last_x;
        logic v, r;
        logic [NOP*WIDTH-1:0] ops;

        // ---- reset ----
        tick();
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sent", sent, 5'd0);
        chk("rst_recv", recv, 5'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_lat", max_lat, 16'd0);
        chk("rst_ops", operands, 96'd0);
        rst = 1'b0;

        // ---- load 8 vectors ----
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = vec(i);
            tick();
        end
        wr_en = 1'b0;

        // ---- scenario 1: 4 vectors, gap 0, latency 3 ----
        num_vec = 5'd4; gap = '0; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_valid", valid, 1'b1);
        chk("s1_busy", busy, 1'b1);
        chk("s1_op0", operands, vec(0));
        tick();
        chk("s1_op1", operands, vec(1));
        chk("s1_sent1", sent, 5'd1);
        tick();
        chk("s1_op2", operands, vec(2));
        tick();
        chk("s1_op3", operands, vec(3));
        chk("s1_sent3", sent, 5'd3);
        resp = 1'b1;
        tick();
        chk("s1_sent4", sent, 5'd4);
        chk("s1_valid_drain", valid, 1'b0);
        chk("s1_busy_drain", busy, 1'b1);
        chk("s1_recv1", recv, 5'd1);
        chk("s1_lat1", max_lat, EXP_LAT);
        tick();
        chk("s1_recv2", recv, 5'd2);
        tick();
        chk("s1_recv3", recv, 5'd3);
        tick();
        resp = 1'b0;
        chk("s1_recv4", recv, 5'd4);
        chk("s1_done_early", done, 1'b0);
        tick();
        chk("s1_done", done, 1'b1);
        chk("s1_busy_done", busy, 1'b0);
        chk("s1_err", err, 1'b0);
        chk("s1_lat", max_lat, EXP_LAT);
        chk("s1_ops_done", operands, 96'd0);
        ready = 1'b0;

        // ---- scenario 2: 8 vectors, gap 2, ready toggling ----
        num_vec = 5'd8; gap = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0; nx = 0; nr = 0; last_x = -100; r = 1'b0;
        while (!done && cyc < 300) begin
            ready = r;
            resp  = (nx > nr);
            v = valid; ops = operands;
            tick();
            cyc++;
            if (resp) nr++;
            if (v && r) begin
                chk("s2_order", ops, vec(nx));
                chk("s2_spacing", (cyc - last_x) >= 3, 1'b1);
                last_x = cyc;
                nx++;
            end else if (v) begin
                chk("s2_hold_ops", operands, ops);
                chk("s2_hold_valid", valid, 1'b1);
            end
            r = ~r;
        end
        ready = 1'b0; resp = 1'b0;
        chk("s2_no_timeout", cyc < 300, 1'b1);
        chk("s2_count", 32'(nx), 32'd8);
        chk("s2_sent", sent, 5'd8);
        chk("s2_recv", recv, 5'd8);
        chk("s2_err", err, 1'b0);

        // ---- scenarios 3/4: stray response in IDLE, then empty run ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resp = 1'b1;
        tick();
        resp = 1'b0;
        chk("s4_err", err, 1'b1);
        chk("s4_recv", recv, 5'd0);
        tick();
        chk("s4_err_sticky", err, 1'b1);
        num_vec = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("s3_done", done, 1'b1);
        chk("s3_err_clr", err, 1'b0);
        chk("s3_valid", valid, 1'b0);
        chk("s3_busy", busy, 1'b0);
        chk("s3_sent", sent, 5'd0);
        tick();
        chk("s3_valid2", valid, 1'b0);
        chk("s3_recv", recv, 5'd0);

        // ---- scenario 5: reset mid-run, table preserved ----
        num_vec = 5'd5; gap = '0; ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = '0; wr_data = {96{1'b1}};   // dropped: not idle
        tick();
        wr_en = 1'b0;
        tick();
        chk("s5_sent2", sent, 5'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_valid", valid, 1'b0);
        chk("s5_sent0", sent, 5'd0);
        chk("s5_busy", busy, 1'b0);
        chk("s5_done", done, 1'b0);
        num_vec = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("s5_restart_valid", valid, 1'b1);
        chk("s5_restart_op0", operands, vec(0));
        tick();
        ready = 1'b0;
        chk("s5_restart_sent", sent, 5'd1);
        resp = 1'b1;
        tick();
        resp = 1'b0;
        chk("s5_restart_recv", recv, 5'd1);
        tick();
        chk("s5_restart_done", done, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
